// File: rtl/seq_det_pkg.sv
// Shared elaboration-time helpers for serial pattern detectors.
// Pattern bit w-1 is the first bit received; bit 0 completes a match.
package seq_det_pkg;

   localparam int MAX_W = 16;

   function automatic int state_w(input int w);
      return $clog2(w + 1);
   endfunction

   // Longest proper prefix of the pattern that is also a suffix of it.
   function automatic int border_len(
      input logic [MAX_W-1:0] pat,
      input int               w
   );
      int best;
      bit ok;
      best = 0;
      for (int k = 1; k < w; k++) begin
         ok = 1'b1;
         for (int i = 0; i < k; i++) begin
            if (pat[w-1-i] != pat[k-1-i]) ok = 1'b0;
         end
         if (ok) best = k;
      end
      return best;
   endfunction

   // Matched-prefix length after appending bit b to a k-bit matched prefix.
   function automatic int next_k(
      input logic [MAX_W-1:0] pat,
      input int               w,
      input int               k,
      input logic             b
   );
      int   best;
      int   j;
      bit   ok;
      logic sb;
      best = 0;
      for (int m = 1; m <= w; m++) begin
         if (m <= k + 1) begin
            ok = 1'b1;
            for (int i = 0; i < m; i++) begin
               j  = k + 1 - m + i;
               sb = (j == k) ? b : pat[w-1-j];
               if (sb != pat[w-1-i]) ok = 1'b0;
            end
            if (ok) best = m;
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/seq_det_og.sv
// Match output decode for the pattern detector, Mealy or Moore.
// Purely combinational: state, x, en -> z.
module seq_det_og
   import seq_det_pkg::*;
#(
   parameter int PAT_W    = 4,
   parameter int S_W      = state_w(PAT_W),
   parameter bit LAST_BIT = 1'b1,
   parameter bit MEALY    = 1'b1
) (
   input  logic [S_W-1:0] state_i,
   input  logic           x_i,
   input  logic           en_i,
   output logic           z_o
);

   if (MEALY) begin : g_mealy
      assign z_o = en_i
                && (state_i == S_W'(PAT_W - 1))
                && (x_i == LAST_BIT);
   end else begin : g_moore
      logic unused_in;
      assign unused_in = x_i ^ en_i;
      assign z_o = (state_i == S_W'(PAT_W));
   end

endmodule

// File: rtl/seq_det.sv
// Parametrised serial pattern detector with table-driven next state.
// Define SEQDET_COUNT_EN to add the saturating match_cnt / cnt_clr ports.
module seq_det
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit               OVERLAP = 1'b1,
   parameter bit               MEALY   = 1'b1,
`ifdef SEQDET_COUNT_EN
   parameter int               COUNT_W = 8,
`endif
   localparam int              S_W     = state_w(PAT_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               x,
   output logic               z,
   output logic [S_W-1:0]     state
`ifdef SEQDET_COUNT_EN
   ,
   output logic [COUNT_W-1:0] match_cnt,
   input  logic               cnt_clr
`endif
);

   localparam int NST    = 2 ** S_W;
   localparam int MAX_ST = MEALY ? PAT_W - 1 : PAT_W;
   localparam int BORDER = border_len(MAX_W'(PATTERN), PAT_W);

   // Full match folds back to the border (or empty) in Mealy mode;
   // Moore parks in PAT_W and resumes from the border on the next bit.
   function automatic int step_of(input int s, input logic b);
      int base;
      int m;
      if (s > MAX_ST) return 0;
      base = (s == PAT_W) ? (OVERLAP ? BORDER : 0) : s;
      m    = next_k(MAX_W'(PATTERN), PAT_W, base, b);
      if (MEALY && m == PAT_W) m = OVERLAP ? BORDER : 0;
      return m;
   endfunction

   logic [S_W-1:0] tbl [2][NST];
   logic [S_W-1:0] state_d;
   logic [S_W-1:0] state_q;

   for (genvar s = 0; s < NST; s++) begin : g_st
      for (genvar b = 0; b < 2; b++) begin : g_bit
         localparam int NX = step_of(s, 1'(b));
         assign tbl[b][s] = S_W'(NX);
      end
   end

   assign state_d = tbl[x][state_q];
   assign state   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
      end else if (en) begin
         state_q <= state_d;
      end
   end

   seq_det_og #(
      .PAT_W    (PAT_W),
      .S_W      (S_W),
      .LAST_BIT (PATTERN[0]),
      .MEALY    (MEALY)
   ) u_og (
      .state_i (state_q),
      .x_i     (x),
      .en_i    (en),
      .z_o     (z)
   );

`ifdef SEQDET_COUNT_EN
   logic               hit;
   logic [COUNT_W-1:0] cnt_q;

   assign hit = MEALY ? z : (en && state_d == S_W'(PAT_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (cnt_clr) begin
         cnt_q <= '0;
      end else if (hit && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign match_cnt = cnt_q;
`endif

endmodule
